// File: rtl/accel_pkg.sv
// Purpose : shared opcodes, register map, init values and FSM state type for accel_ctrl.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package accel_pkg;

    // SPI opcodes understood by the accelerometer
    localparam logic [7:0] WRITE = 8'h0A;
    localparam logic [7:0] READ  = 8'h0B;

    // Accelerometer register addresses
    localparam logic [7:0] XDATA      = 8'h08;
    localparam logic [7:0] YDATA      = 8'h09;
    localparam logic [7:0] FILTER_CTL = 8'h2C;
    localparam logic [7:0] POWER_CTL  = 8'h2D;

    // Values written during the init sequence
    localparam logic [7:0] FILTER_INIT = 8'h17;
    localparam logic [7:0] POWER_INIT  = 8'h02;

    typedef enum logic [2:0] {
        S_FILT,
        S_POWER,
        S_WAIT,
        S_READ,
        S_GAP
    } state_t;

    // Command presented to the SPI master
    typedef struct packed {
        logic [7:0] instr;
        logic [7:0] addr;
        logic [7:0] data;
    } spi_cmd_t;

    // States that own an SPI transaction
    function automatic logic is_req(state_t s);
        return (s == S_FILT) || (s == S_POWER) || (s == S_READ);
    endfunction

    // Where a transaction state goes (via S_GAP) after a successful finish
    function automatic state_t ok_successor(state_t s);
        state_t n;
        case (s)
            S_FILT:  n = S_POWER;
            default: n = S_WAIT;
        endcase
        return n;
    endfunction

    // One burst read starting at XDATA returns both X and Y bytes
    function automatic spi_cmd_t cmd_for(state_t s);
        spi_cmd_t c;
        case (s)
            S_POWER: c = '{instr: WRITE, addr: POWER_CTL, data: POWER_INIT};
            S_READ:  c = '{instr: READ,  addr: XDATA,     data: 8'h00};
            default: c = '{instr: WRITE, addr: FILTER_CTL, data: FILTER_INIT};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/accel_avg4.sv
// Purpose : moving average of the last four signed 8-bit samples of one axis.
// Latency : 1 clk from in_vld to out_dat update.
// Backpressure: none; every in_vld sample is accepted.
// Ports   : clk, reset (sync, active-high), in_vld/in_dat (new sample), out_dat (averaged sample).
module accel_avg4 (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_vld,
    input  logic [7:0] in_dat,
    output logic [7:0] out_dat
);

    // Three previous samples; newest at index 0
    logic [2:0][7:0]   hist;
    logic signed [9:0] sum;
    logic              unused_frac;

    always_comb begin
        sum = $signed({{2{in_dat[7]}},  in_dat})
            + $signed({{2{hist[0][7]}}, hist[0]})
            + $signed({{2{hist[1][7]}}, hist[1]})
            + $signed({{2{hist[2][7]}}, hist[2]});
    end

    // sum >>> 2 truncated to 8 bits is exactly sum[9:2]; the fraction is dropped
    assign unused_frac = ^sum[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            hist    <= '0;
            out_dat <= '0;
        end else if (in_vld) begin
            hist    <= {hist[1:0], in_dat};
            out_dat <= sum[9:2];
        end
    end

endmodule

// File: rtl/accel_ctrl.sv
// Purpose : drives accelerometer init writes then periodic XY burst reads over an SPI master.
// Latency : samples appear 1 clk after the READ finish; reads start every SAMPLE_DIV+gap clks.
// Backpressure: spi_start held until spi_finish or TIMEOUT clks; timeouts flag spi_error and retry.
// Ports   : clk/reset (sync, active-high); spi_start/instr/addr/data -> SPI master,
//           spi_finish/xdata/ydata <- SPI master; x_accel/y_accel/sample_valid sample output;
//           init_done, spi_error status. Build option: ACCEL_AVG_EN adds 4-sample averaging.
module accel_ctrl
    import accel_pkg::*;
#(
    parameter int         SAMPLE_DIV = 100000,
    parameter int         TIMEOUT    = 255,
    parameter logic [7:0] Y_OFFSET   = 8'd6
) (
    input  logic       clk,
    input  logic       reset,
    output logic       spi_start,
    output logic [7:0] spi_instr,
    output logic [7:0] spi_addr,
    output logic [7:0] spi_data,
    input  logic       spi_finish,
    input  logic [7:0] spi_xdata,
    input  logic [7:0] spi_ydata,
    output logic [7:0] x_accel,
    output logic [7:0] y_accel,
    output logic       sample_valid,
    output logic       init_done,
    output logic       spi_error
);

    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t         state, state_nxt;
    state_t         after_gap, after_gap_nxt;
    spi_cmd_t       cmd_q, cmd_nxt;
    logic           start_nxt;
    logic           init_nxt;
    logic           err_nxt;
    logic           capture;
    logic [DW-1:0]  wait_cnt;
    logic [TW-1:0]  tmo_cnt;
    logic           done_ok;
    logic           tmo_hit;
    logic [7:0]     y_corr;

    // A finish only counts while a request is outstanding; finish on the
    // expiry cycle wins over the timeout.
    assign done_ok = spi_start && spi_finish;
    assign tmo_hit = spi_start && !spi_finish && (tmo_cnt == TW'(TIMEOUT - 1));

    assign spi_instr = cmd_q.instr;
    assign spi_addr  = cmd_q.addr;
    assign spi_data  = cmd_q.data;

    // ---------------- state register (and registered FSM outputs) ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_FILT;
            after_gap    <= S_FILT;
            spi_start    <= 1'b0;
            cmd_q        <= cmd_for(S_FILT);
            sample_valid <= 1'b0;
            init_done    <= 1'b0;
            spi_error    <= 1'b0;
        end else begin
            state        <= state_nxt;
            after_gap    <= after_gap_nxt;
            spi_start    <= start_nxt;
            cmd_q        <= cmd_nxt;
            sample_valid <= capture;
            init_done    <= init_nxt;
            spi_error    <= err_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt     = state;
        after_gap_nxt = after_gap;
        unique case (state)
            S_FILT, S_POWER, S_READ: begin
                if (done_ok) begin
                    state_nxt     = S_GAP;
                    after_gap_nxt = ok_successor(state);
                end else if (tmo_hit) begin
                    // retry the same transaction after the gap
                    state_nxt     = S_GAP;
                    after_gap_nxt = state;
                end
            end
            S_GAP:   state_nxt = after_gap;
            S_WAIT:  if (wait_cnt == '0) state_nxt = S_READ;
            default: state_nxt = S_FILT;
        endcase
    end

    // ---------------- output logic (next values of registered outputs) ----------------
    // spi_start follows the state being entered, so it rises on the same edge
    // the FSM enters a transaction state. After reset the FSM already sits in
    // S_FILT with spi_start low, so the first edge out of reset raises it.
    always_comb begin
        start_nxt = is_req(state_nxt);
        cmd_nxt   = cmd_q;
        if (is_req(state_nxt)) begin
            cmd_nxt = cmd_for(state_nxt);
        end
        capture  = done_ok && (state == S_READ);
        init_nxt = init_done || (done_ok && (state == S_POWER));
        err_nxt  = spi_error || tmo_hit;
    end

    // ---------------- counters ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            if ((state_nxt == S_WAIT) && (state != S_WAIT)) begin
                wait_cnt <= DW'(SAMPLE_DIV - 1);
            end else if ((state == S_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - DW'(1);
            end
            // counts cycles spent with the request outstanding
            tmo_cnt <= spi_start ? tmo_cnt + TW'(1) : '0;
        end
    end

    // ---------------- sample path ----------------
    assign y_corr = spi_ydata - Y_OFFSET;

`ifdef ACCEL_AVG_EN
    accel_avg4 u_avg_x (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (capture),
        .in_dat  (spi_xdata),
        .out_dat (x_accel)
    );

    accel_avg4 u_avg_y (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (capture),
        .in_dat  (y_corr),
        .out_dat (y_accel)
    );
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            x_accel <= '0;
            y_accel <= '0;
        end else if (capture) begin
            x_accel <= spi_xdata;
            y_accel <= y_corr;
        end
    end
`endif

endmodule

// File: tb/tb_accel_ctrl.sv
// Purpose : self-checking bench for accel_ctrl with a latency-programmable SPI slave model.
// Latency : n/a.
// Backpressure: slave finishes after a per-transaction latency (0 = never, forcing a timeout).
module tb_accel_ctrl;

    localparam int SDIV = 64;
    localparam int TMO  = 255;
    localparam int YOFF = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spi_start;
    logic [7:0] spi_instr, spi_addr, spi_data;
    logic       spi_finish = 1'b0;
    logic [7:0] spi_xdata = 8'h00;
    logic [7:0] spi_ydata = 8'h00;
    logic [7:0] x_accel, y_accel;
    logic       sample_valid, init_done, spi_error;

    always #5 clk = ~clk;

    accel_ctrl #(
        .SAMPLE_DIV (SDIV),
        .TIMEOUT    (TMO),
        .Y_OFFSET   (8'(YOFF))
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .spi_start    (spi_start),
        .spi_instr    (spi_instr),
        .spi_addr     (spi_addr),
        .spi_data     (spi_data),
        .spi_finish   (spi_finish),
        .spi_xdata    (spi_xdata),
        .spi_ydata    (spi_ydata),
        .x_accel      (x_accel),
        .y_accel      (y_accel),
        .sample_valid (sample_valid),
        .init_done    (init_done),
        .spi_error    (spi_error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Transaction kinds: 0 = filter write, 1 = power write, 2 = XY read
    function automatic logic [23:0] tx_cmd(input int t);
        case (t)
            0:       return 24'h0A2C17;
            1:       return 24'h0A2D02;
            default: return 24'h0B0800;
        endcase
    endfunction

    // Slave latency per transaction (index counts every spi_start rise).
    // 0 -> never finish. Index 3 finishes on the very cycle the timeout expires.
    function automatic int lat_for(input int idx);
        case (idx)
            0, 10:         return 0;
            1, 2, 11, 12:  return 20;
            3:             return TMO;
            default:       return int'($urandom_range(1, 40));
        endcase
    endfunction

    // Reference model state
    int          exp_tx, cur_tx, gap_exp;
    bit          exp_init, exp_err;
    int          run_hi, run_lo;
    bit          prev_start;
    bit          prev_rst = 1'b1;
    bit          hs;
    logic [23:0] cmd, prev_cmd;
    int          rises, reads, samples;
    int          scnt, cur_lat;
    int          stab_err, flag_err, spur_err;
    logic [7:0]  rx, ry, ycor, ex, ey;
`ifdef ACCEL_AVG_EN
    int          hx[$];
    int          hy[$];
    int          sx, sy;
`endif

    // Monitor + SPI slave: observe at negedge, drive spi_finish for the next posedge
    initial begin
        {exp_tx, cur_tx, gap_exp, run_hi, run_lo, rises, reads, samples} = '0;
        {scnt, cur_lat, stab_err, flag_err, spur_err} = '0;
        {exp_init, exp_err, prev_start} = '0;
        prev_cmd = '0;
        rx = 8'h00;
        ry = 8'h00;
        forever begin
            @(negedge clk);
            cmd = {spi_instr, spi_addr, spi_data};
            hs  = spi_finish && prev_start;
            if (prev_rst) begin
                check("rst_spi_start", spi_start, 0);
                check("rst_spi_instr", spi_instr, 8'h0A);
                check("rst_spi_addr", spi_addr, 8'h2C);
                check("rst_spi_data", spi_data, 8'h17);
                check("rst_x_accel", x_accel, 0);
                check("rst_y_accel", y_accel, 0);
                check("rst_sample_valid", sample_valid, 0);
                check("rst_init_done", init_done, 0);
                check("rst_spi_error", spi_error, 0);
                exp_tx   = 0;
                exp_init = 1'b0;
                exp_err  = 1'b0;
                gap_exp  = -1;
                run_hi   = 0;
                run_lo   = 0;
                scnt     = 0;
                spi_finish = 1'b0;
`ifdef ACCEL_AVG_EN
                hx.delete();
                hy.delete();
`endif
            end else begin
                if (hs) begin
                    check("start_drop_after_finish", spi_start, 0);
                    if (cur_tx == 1) exp_init = 1'b1;
                    if (cur_tx == 2) begin
                        ycor = 8'(int'(ry) - YOFF);
`ifdef ACCEL_AVG_EN
                        hx.push_back(int'($signed(rx)));
                        hy.push_back(int'($signed(ycor)));
                        if (hx.size() > 4) void'(hx.pop_front());
                        if (hy.size() > 4) void'(hy.pop_front());
                        sx = 0;
                        sy = 0;
                        foreach (hx[i]) sx += hx[i];
                        foreach (hy[i]) sy += hy[i];
                        ex = 8'(sx >>> 2);
                        ey = 8'(sy >>> 2);
`else
                        ex = rx;
                        ey = ycor;
`endif
                        check("sample_valid_on_read", sample_valid, 1);
                        check("x_accel", x_accel, ex);
                        check("y_accel", y_accel, ey);
                        samples++;
                    end
                    gap_exp = (cur_tx == 0) ? 1 : SDIV;
                    exp_tx  = (cur_tx == 0) ? 1 : 2;
                end else if (prev_start && !spi_start) begin
                    exp_err = 1'b1;
                    check("timeout_length", run_hi, TMO);
                    check("timeout_sets_error", spi_error, 1);
                    gap_exp = 1;
                end
                if (sample_valid && !(hs && cur_tx == 2)) spur_err++;
                if ((init_done !== exp_init) || (spi_error !== exp_err)) flag_err++;

                if (spi_start && !prev_start) begin
                    if (gap_exp == 1)
                        check("gap_one_cycle", run_lo, 1);
                    else if (gap_exp > 1)
                        check("read_spacing", (run_lo >= SDIV) && (run_lo <= SDIV + 2), 1);
                    check("tx_command", cmd, tx_cmd(exp_tx));
                    cur_tx  = exp_tx;
                    cur_lat = lat_for(rises);
                    rises++;
                    scnt    = 0;
                    run_hi  = 0;
                    if (cur_tx == 2) begin
`ifdef ACCEL_AVG_EN
                        rx = (reads < 4) ? 8'h08 : 8'($urandom);
`else
                        rx = (reads < 2) ? 8'h10 : 8'($urandom);
`endif
                        ry = (reads == 0) ? 8'h0A : (reads == 1) ? 8'h03 : 8'($urandom);
                        reads++;
                    end
                end else if (spi_start && prev_start && (cmd !== prev_cmd)) begin
                    stab_err++;
                end

                if (spi_start) begin
                    run_hi++;
                    run_lo = 0;
                end else begin
                    run_lo++;
                end

                // SPI slave: one-cycle finish pulse after cur_lat observed request cycles
                if (spi_finish) begin
                    spi_finish = 1'b0;
                end else if (spi_start) begin
                    scnt++;
                    if ((cur_lat != 0) && (scnt == cur_lat)) spi_finish = 1'b1;
                end
                if (spi_finish) begin
                    spi_xdata = rx;
                    spi_ydata = ry;
                end else begin
                    spi_xdata = 8'($urandom);
                    spi_ydata = 8'($urandom);
                end
            end
            prev_start = spi_start;
            prev_cmd   = cmd;
            prev_rst   = reset;
        end
    end

    // Main sequence: reset, timeout + retry, init, reads, reset mid-read, restart
    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 6000 && rises < 11; i++) begin
            @(posedge clk);
            #1;
        end
        check("rises_before_midread_reset", rises, 11);
        check("reads_before_midread_reset", samples, 7);
        check("init_done_after_init", init_done, 1);
        check("spi_error_sticky", spi_error, 1);

        // rise 10 is a READ the slave never finishes; reset it partway through
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("midread_start_high", spi_start, 1);
        check("midread_addr", spi_addr, 8'h08);
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;

        for (int i = 0; i < 3000 && samples < 8; i++) begin
            @(posedge clk);
            #1;
        end
        check("reads_after_reset", samples, 8);
        check("rises_total", rises, 14);
        check("init_done_after_restart", init_done, 1);
        check("spi_error_cleared_by_reset", spi_error, 0);
        check("cmd_stable_while_start", stab_err, 0);
        check("status_flags_track_model", flag_err, 0);
        check("no_spurious_sample_valid", spur_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
